// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: HD44780 8-bit write-only sequencer, power-up/init then full 20-char line-1 rewrites on request.
// Optional LCD_DIGIT_TO_ASCII_EN maps snapshot bytes 0x00..0x09 to ASCII '0'..'9' on the way out.
module lcd_refresh_ctrl #(
    parameter int POWERUP_CYC    = 2_000_000,
    parameter int E_PULSE_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2_500,
    parameter int CLEAR_WAIT_CYC = 100_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [159:0] lcd_data,
    input  logic         refresh_req,
    output logic         busy,
    output logic         done,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [7:0]   lcd_db
);
    localparam int MAX_AB = POWERUP_CYC > CLEAR_WAIT_CYC ? POWERUP_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_CD = E_PULSE_CYC > CMD_WAIT_CYC ? E_PULSE_CYC : CMD_WAIT_CYC;
    localparam int MAXC   = MAX_AB > MAX_CD ? MAX_AB : MAX_CD;
    localparam int TW     = $clog2(MAXC + 1);

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR, CHAR} state_t;
    typedef enum logic [1:0] {SETUP, STROBE, WAIT} phase_t;

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [4:0]     idx_q, idx_d;
    logic [159:0]   snap_q, snap_d;
    logic           pending_q, pending_d;
    logic           tmr_zero, byte_end, go, engine;
    logic [TW-1:0]  wait_ld;
    logic [7:0]     cmd_byte, char_byte;

    assign tmr_zero = tmr_q == '0;
    assign byte_end = phase_q == WAIT && tmr_zero;
    assign go       = refresh_req | pending_q;
    assign engine   = state_q == INIT || state_q == ADDR || state_q == CHAR;
    assign wait_ld  = (state_q == INIT && idx_q == 5'd3) ? TW'(CLEAR_WAIT_CYC - 1) : TW'(CMD_WAIT_CYC - 1);
    assign lcd_rw   = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PWRUP;
            phase_q   <= SETUP;
            tmr_q     <= TW'(POWERUP_CYC - 1);
            idx_q     <= '0;
            snap_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            tmr_q     <= tmr_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PWRUP:   if (tmr_zero) state_d = INIT;
            INIT:    if (byte_end && idx_q == 5'd3) state_d = IDLE;
            IDLE:    if (go) state_d = ADDR;
            ADDR:    if (byte_end) state_d = CHAR;
            CHAR:    if (byte_end && idx_q == 5'd19) state_d = IDLE;
            default: state_d = PWRUP;
        endcase
    end

    // One SETUP/STROBE/WAIT byte engine shared by INIT, ADDR and CHAR.
    always_comb begin
        phase_d   = phase_q;
        tmr_d     = tmr_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        pending_d = (state_q == IDLE) ? 1'b0 : pending_q | refresh_req;
        if (state_q == PWRUP) begin
            tmr_d = tmr_zero ? '0 : tmr_q - 1'b1;
        end else if (engine) begin
            case (phase_q)
                SETUP: begin
                    phase_d = STROBE;
                    tmr_d   = TW'(E_PULSE_CYC - 1);
                end
                STROBE: begin
                    phase_d = tmr_zero ? WAIT : STROBE;
                    tmr_d   = tmr_zero ? wait_ld : tmr_q - 1'b1;
                end
                WAIT: begin
                    phase_d = tmr_zero ? SETUP : WAIT;
                    tmr_d   = tmr_zero ? '0 : tmr_q - 1'b1;
                end
                default: phase_d = SETUP;
            endcase
        end
        if (state_d != state_q)
            idx_d = '0;
        else if (byte_end)
            idx_d = idx_q + 1'b1;
        // The snapshot shifts left so the current character is always the top byte.
        if (state_q == IDLE && go)
            snap_d = lcd_data;
        else if (state_q == CHAR && byte_end)
            snap_d = {snap_q[151:0], 8'h00};
    end

    always_comb begin
`ifdef LCD_DIGIT_TO_ASCII_EN
        char_byte = (snap_q[159:152] < 8'h0A) ? snap_q[159:152] + 8'h30 : snap_q[159:152];
`else
        char_byte = snap_q[159:152];
`endif
        cmd_byte = idx_q == 5'd0 ? 8'h38 : idx_q == 5'd1 ? 8'h0C : idx_q == 5'd2 ? 8'h06 : 8'h01;
        done     = state_q == CHAR && byte_end && idx_q == 5'd19;
        busy     = state_q != IDLE && !done;
        lcd_e    = phase_q == STROBE;
        lcd_rs   = state_q == CHAR;
        lcd_db   = state_q == INIT ? cmd_byte :
                   state_q == ADDR ? 8'h80 :
                   state_q == CHAR ? char_byte : 8'h00;
    end
endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb_lcd_refresh_ctrl: cycle trace checks against an expected waveform built from byte lists, plus table and random refreshes.
module tb_lcd_refresh_ctrl;
    localparam int PW = 20, EP = 2, CW = 4, CL = 10;
    localparam int RLEN = 21 * (1 + EP + CW);
`ifdef LCD_DIGIT_TO_ASCII_EN
    localparam bit CONV = 1'b1;
`else
    localparam bit CONV = 1'b0;
`endif

    typedef struct {
        logic       e;
        logic       rs;
        logic [7:0] db;
        logic       busy;
        logic       done;
        logic       care;
    } exp_t;

    typedef struct {
        int         k;
        logic [7:0] din;
        logic [7:0] dexp;
    } vec_t;

    logic         clk, rst_n, refresh_req;
    logic [159:0] lcd_data;
    logic         busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]   lcd_db;

    exp_t       expq[$];
    logic [7:0] capq[$];
    int         errors = 0, checks = 0;
    int         cyc = 0, t_rise = 0, last_len = 0;
    logic       prev_e = 1'b0, prev_busy = 1'b1;

    lcd_refresh_ctrl #(
        .POWERUP_CYC(PW), .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CW), .CLEAR_WAIT_CYC(CL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .refresh_req(refresh_req),
        .busy(busy), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] sent(input logic [7:0] b);
        return (CONV && b < 8'h0A) ? b + 8'h30 : b;
    endfunction

    function automatic logic [159:0] rnd_line();
        logic [159:0] r;
        int v;
        for (int k = 0; k < 20; k++) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            r[159-8*k -: 8] = 8'(v);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic e, input logic rs, input logic [7:0] db, input logic b, input logic d, input logic care);
        exp_t x;
        x.e = e; x.rs = rs; x.db = db; x.busy = b; x.done = d; x.care = care;
        expq.push_back(x);
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] db, input int wt, input logic last);
        push(1'b0, rs, db, 1'b1, 1'b0, 1'b1);
        repeat (EP) push(1'b1, rs, db, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < wt; i++)
            push(1'b0, rs, db, !(last && i == wt - 1), last && i == wt - 1, 1'b1);
    endtask

    task automatic push_idle(input int n);
        repeat (n) push(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_pwrup_init();
        repeat (PW - 1) push(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        push_byte(1'b0, 8'h38, CW, 1'b0);
        push_byte(1'b0, 8'h0C, CW, 1'b0);
        push_byte(1'b0, 8'h06, CW, 1'b0);
        push_byte(1'b0, 8'h01, CL, 1'b0);
    endtask

    task automatic push_refresh(input logic [159:0] d);
        push_byte(1'b0, 8'h80, CW, 1'b0);
        for (int k = 0; k < 20; k++)
            push_byte(1'b1, sent(d[159-8*k -: 8]), CW, k == 19);
    endtask

    task automatic step();
        exp_t x;
        @(negedge clk);
        cyc++;
        if (lcd_e === 1'b1 && prev_e === 1'b0 && lcd_rs === 1'b1) capq.push_back(lcd_db);
        if (busy === 1'b1 && prev_busy === 1'b0) t_rise = cyc;
        if (done === 1'b1) last_len = cyc - t_rise + 1;
        prev_e = lcd_e;
        prev_busy = busy;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL trace underrun at cycle %0d", cyc);
        end else begin
            x = expq.pop_front();
            if (lcd_e !== x.e || busy !== x.busy || done !== x.done || lcd_rw !== 1'b0 ||
                (x.care && (lcd_rs !== x.rs || lcd_db !== x.db))) begin
                errors++;
                $display("FAIL trace cycle %0d: e/rs/db/busy/done got %b/%b/%h/%b/%b expected %b/%b/%h/%b/%b",
                         cyc, lcd_e, lcd_rs, lcd_db, busy, done, x.e, x.rs, x.db, x.busy, x.done);
            end
        end
    endtask

    task automatic drain();
        while (expq.size() > 0) step();
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_e"}, 32'(lcd_e), 32'd0);
        chk({tag, "_db"}, 32'(lcd_db), 32'h00);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rs"}, 32'(lcd_rs), 32'd0);
        chk({tag, "_rw"}, 32'(lcd_rw), 32'd0);
    endtask

    initial begin
        vec_t tbl[8];
        logic [159:0] d, d2;
        bit pend;
        int g;

        tbl[0] = '{4, 8'h01, CONV ? 8'h31 : 8'h01};
        tbl[1] = '{5, 8'h02, CONV ? 8'h32 : 8'h02};
        tbl[2] = '{0, 8'h00, CONV ? 8'h30 : 8'h00};
        tbl[3] = '{9, 8'h09, CONV ? 8'h39 : 8'h09};
        tbl[4] = '{10, 8'h0A, 8'h0A};
        tbl[5] = '{11, 8'h2F, 8'h2F};
        tbl[6] = '{12, 8'h30, 8'h30};
        tbl[7] = '{19, 8'hFF, 8'hFF};

        rst_n = 1'b0;
        refresh_req = 1'b0;
        lcd_data = '0;
        @(negedge clk);
        rst_checks("reset");
        rst_n = 1'b1;
        push_pwrup_init();
        push_idle(3);
        drain();

        // Table-driven refresh: digit boundaries and the 0x01/0x02 pair.
        d = {20{8'h20}};
        foreach (tbl[i]) d[159-8*tbl[i].k -: 8] = tbl[i].din;
        lcd_data = d;
        refresh_req = 1'b1;
        capq.delete();
        push_refresh(d);
        step();
        refresh_req = 1'b0;
        drain();
        push_idle(2);
        drain();
        chk("cap_count", capq.size(), 20);
        chk("refresh_len", last_len, RLEN);
        foreach (tbl[i]) chk($sformatf("tbl%0d_char%0d", i, tbl[i].k), 32'(capq[tbl[i].k]), 32'(tbl[i].dexp));

        // Three requests during one refresh collapse into exactly one follow-up.
        d = rnd_line();
        d2 = rnd_line();
        lcd_data = d;
        refresh_req = 1'b1;
        push_refresh(d);
        step();
        refresh_req = 1'b0;
        for (int i = 2; i <= RLEN; i++) begin
            step();
            refresh_req = (i == 10 || i == 60 || i == 120);
        end
        lcd_data = d2;
        push_idle(1);
        push_refresh(d2);
        push_idle(3);
        drain();

        // Request held high: back-to-back refreshes with one idle cycle between.
        d = rnd_line();
        lcd_data = d;
        refresh_req = 1'b1;
        push_refresh(d);
        push_idle(1);
        push_refresh(d);
        repeat (RLEN + 2) step();
        refresh_req = 1'b0;
        push_idle(2);
        drain();

        // Buffer change mid-refresh must not leak into the bytes being sent.
        lcd_data = {20{8'h41}};
        refresh_req = 1'b1;
        push_refresh({20{8'h41}});
        step();
        refresh_req = 1'b0;
        for (int i = 2; i <= RLEN; i++) begin
            step();
            if (i == 8 + 7 * 10) lcd_data = {20{8'h42}};
        end
        push_idle(2);
        drain();

        // Random buffers, gaps and stray requests against the pending rule.
        pend = 1'b0;
        for (int it = 0; it < 12; it++) begin
            d = rnd_line();
            if (pend) begin
                push_idle(1);
                step();
            end else begin
                g = $urandom_range(1, 4);
                push_idle(g);
                repeat (g) step();
            end
            lcd_data = d;
            refresh_req = !pend;
            pend = 1'b0;
            push_refresh(d);
            for (int i = 1; i <= RLEN; i++) begin
                step();
                refresh_req = (it < 11) && ($urandom_range(0, 39) == 0);
                pend |= refresh_req;
                if ($urandom_range(0, 7) == 0) lcd_data = rnd_line();
            end
        end
        refresh_req = 1'b0;
        push_idle(3);
        drain();

        // Reset during char 7 strobe, then a request during the rerun of INIT.
        d = rnd_line();
        lcd_data = d;
        refresh_req = 1'b1;
        push_refresh(d);
        step();
        refresh_req = 1'b0;
        repeat (8 + 7 * 7) step();
        chk("pre_reset_strobe", 32'(lcd_e), 32'd1);
        rst_n = 1'b0;
        #1;
        rst_checks("midreset");
        expq.delete();
        repeat (3) push(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        repeat (3) step();
        rst_n = 1'b1;
        d2 = rnd_line();
        lcd_data = d2;
        push_pwrup_init();
        push_idle(1);
        push_refresh(d2);
        push_idle(2);
        repeat (PW - 1 + 10) step();
        refresh_req = 1'b1;
        step();
        refresh_req = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lcd_refresh_ctrl.md
Name: lcd_refresh_ctrl

Overview:
- Sequences a 20-character, 160-bit line buffer onto an HD44780-compatible character LCD over an 8-bit parallel bus, write-only.
- Sits between the stopwatch display packer, which supplies the 160-bit line, and the LCD pins.
- After reset, runs the power-up wait and the init command sequence; then waits for refresh requests.
- Each refresh rewrites DDRAM line 1, addresses 0x00..0x13, from a snapshot of the buffer.

Parameters:
POWERUP_CYC, 2_000_000, cycles to wait after reset before the first command (40 ms at 50 MHz)
E_PULSE_CYC, 25, cycles lcd_e is held high per byte
CMD_WAIT_CYC, 2_500, cycles lcd_e is held low after each byte (50 us)
CLEAR_WAIT_CYC, 100_000, cycles lcd_e is held low after the clear command (2 ms)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
lcd_data  in  160  line buffer; character k (0..19) = lcd_data[159-8k -: 8]
refresh_req  in  1  request one full-line rewrite; sampled every clk
busy  out  1  high during power-up, init or a refresh
done  out  1  one-cycle pulse when a refresh completes
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  tied 0 (write only)
lcd_e  out  1  LCD enable strobe
lcd_db  out  8  LCD data bus

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, busy=1, done=0, pending=0, FSM=PWRUP.
- Asserting rst_n at any time, including mid-byte, forces the reset values immediately. After release, the full power-up and init sequence reruns.
- Byte write, one per step, is a 3-phase sub-sequence:
  - SETUP, 1 cycle: lcd_rs and lcd_db driven, lcd_e=0.
  - STROBE, E_PULSE_CYC cycles: lcd_e=1.
  - WAIT, CMD_WAIT_CYC cycles, or CLEAR_WAIT_CYC after 0x01: lcd_e=0.
  - lcd_rs and lcd_db stay stable through all three phases.
- FSM states: PWRUP -> INIT -> IDLE -> ADDR -> CHAR -> IDLE.
  - PWRUP: wait POWERUP_CYC cycles, then go to INIT.
  - INIT: send commands in order: 0x38 (8-bit, 2-line, 5x8), 0x0C (display on, cursor off), 0x06 (increment, no shift), 0x01 (clear). All with rs=0.
  - IDLE: busy=0. If refresh_req or pending, capture lcd_data into a 160-bit snapshot register, clear pending, go to ADDR. busy=1 from the next cycle.
  - ADDR: send 0x80 (DDRAM addr 0), rs=0.
  - CHAR: send snapshot characters k=0..19 in order, rs=1. A 5-bit index counter runs 0..19.
  - End of CHAR: at the end of character 19's WAIT, pulse done for 1 cycle and drop busy in the same cycle. The FSM enters IDLE on the next cycle.
- refresh_req asserted while busy, including during PWRUP/INIT, sets pending. Multiple requests collapse into one. The pending request is serviced on the first IDLE cycle.
- refresh_req held high continuously yields back-to-back refreshes with exactly 1 IDLE cycle between them.
- lcd_data changes during a refresh do not affect the bytes already being sent; the snapshot is used.
- Timing counters are wide enough for max(POWERUP_CYC, CLEAR_WAIT_CYC). The index counter never exceeds 19.
- Refresh length = 21 x (1 + E_PULSE_CYC + CMD_WAIT_CYC) cycles, from the first busy cycle to done inclusive.

Optional Feature:
- Macro: LCD_DIGIT_TO_ASCII_EN.
- When defined: in CHAR, any snapshot byte with value 0x00..0x09 is sent as that value + 0x30 (ASCII '0'..'9'). All other bytes are sent unchanged. This lets raw BCD digits from the packer display directly.
- When undefined: bytes are sent verbatim.
- The conversion is purely combinational on the lcd_db path and adds no latency.

Test Plan (POWERUP_CYC=20, E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=10):
- Reset release -> busy=1 for 20 PWRUP cycles. Then lcd_db shows 0x38, 0x0C, 0x06, 0x01 with rs=0, each with a 2-cycle lcd_e pulse. Gaps after the pulse are 4, 4, 4 and 10 cycles. busy falls afterwards.
- lcd_data = all 0x20 except chars 4..5 = 0x01,0x02; one-cycle refresh_req in IDLE -> 0x80 with rs=0, then 20 data bytes. With the macro, bytes 4..5 are 0x31,0x32; without it, 0x01,0x02. done pulses once, 147 cycles after busy rises.
- refresh_req pulsed 3 times during one refresh -> exactly one further refresh, starting 1 cycle after the first done.
- lcd_data changed from all 0x41 to all 0x42 at char 10 of a refresh -> all 20 data bytes are 0x41.
- refresh_req pulsed during INIT -> the first refresh starts on the first IDLE cycle after init.
- rst_n asserted during STROBE of char 7 -> lcd_e=0, lcd_db=0x00, busy=1 immediately. After release, the full PWRUP/INIT sequence repeats and no done pulse occurs.
